// File: rtl/cxapbasyncbridge_cdc_defs.sv
// Shared definitions for the APB async bridge CDC capture bank:
// per-channel state encoding and the legal synchroniser depth range.
package cxapbasyncbridge_cdc_defs;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } chan_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic bit sync_stages_legal(input int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

endpackage

// File: rtl/cxapbasyncbridge_cdc_capt_chan.sv
// One capture channel: request synchroniser, edge detect, IDLE/HOLD FSM,
// gated payload capture, toggle acknowledge and sticky overflow flag.
module cxapbasyncbridge_cdc_capt_chan
    import cxapbasyncbridge_cdc_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CLAMP       = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_async_i,
    input  logic [WIDTH-1:0] d_async_i,
    input  logic             q_ready_i,
    input  logic             ovf_clr_i,
    output logic             ack_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q_valid_o,
    output logic             ovf_o
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_sync_range_err
        $error("cxapbasyncbridge_cdc_capt_chan: SYNC_STAGES out of range 2..4");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_d_q;
    chan_state_e            state_q, state_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   ack_q, ack_d;
    logic                   ovf_q, ovf_d;

    logic                   req_s;
    logic                   req_edge;
    logic                   capt_en;
    logic [WIDTH-1:0]       capt_data;

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign req_edge = req_s ^ req_d_q;
    assign capt_en  = req_edge && (state_q == IDLE);
    // The asynchronous payload only ever passes through this AND gate.
    assign capt_data = d_async_i & {WIDTH{capt_en}};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            req_d_q <= 1'b0;
            state_q <= IDLE;
            data_q  <= '0;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req_async_i};
            req_d_q <= req_s;
            state_q <= state_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ack_d   = ack_q;
        ovf_d   = ovf_q & ~ovf_clr_i;
        unique case (state_q)
            IDLE: begin
                if (req_edge) begin
                    data_d  = capt_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (q_ready_i) begin
                    ack_d   = req_d_q;
                    state_d = IDLE;
                    if (CLAMP != 0) begin
                        data_d = '0;
                    end
                end
                // A new edge while holding is a source violation; set beats clear.
                if (req_edge) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign q_valid_o = (state_q == HOLD);
    assign q_o       = (CLAMP != 0) ? (data_q & {WIDTH{q_valid_o}}) : data_q;
    assign ack_o     = ack_q;
    assign ovf_o     = ovf_q;

`ifdef ARM_CDC_CHECK
    always_ff @(posedge clk_i) begin
        if (!reset_i && capt_en && $isunknown(d_async_i)) begin
            $display("FATAL : Unsafe operation detected across CDC boundary");
            $stop;
        end
    end
`endif

endmodule

// File: rtl/cxapbasyncbridge_cdc_capt_bank.sv
// Destination-domain capture bank: NCHAN independent capture channels,
// each sliced out of the packed request/payload/handshake buses.
module cxapbasyncbridge_cdc_capt_bank
    import cxapbasyncbridge_cdc_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int NCHAN       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CLAMP       = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCHAN-1:0]       req_async,
    input  logic [NCHAN*WIDTH-1:0] d_async,
    output logic [NCHAN-1:0]       ack,
    output logic [NCHAN*WIDTH-1:0] q,
    output logic [NCHAN-1:0]       q_valid,
    input  logic [NCHAN-1:0]       q_ready,
    output logic [NCHAN-1:0]       ovf,
    input  logic [NCHAN-1:0]       ovf_clr
);

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        cxapbasyncbridge_cdc_capt_chan #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES),
            .CLAMP       (CLAMP)
        ) u_chan (
            .clk_i       (clk),
            .reset_i     (reset),
            .req_async_i (req_async[c]),
            .d_async_i   (d_async[c*WIDTH +: WIDTH]),
            .q_ready_i   (q_ready[c]),
            .ovf_clr_i   (ovf_clr[c]),
            .ack_o       (ack[c]),
            .q_o         (q[c*WIDTH +: WIDTH]),
            .q_valid_o   (q_valid[c]),
            .ovf_o       (ovf[c])
        );
    end

endmodule

// File: tb/tb_cxapbasyncbridge_cdc_capt_bank.sv
// Scoreboard bench: stimulus pushes expected captures (data, cycle), a
// negedge monitor pops them on every q_valid rise; directed checks inline.
module tb_cxapbasyncbridge_cdc_capt_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_a, ack_a, qv_a, rdy_a, ovf_a, clr_a;
    logic [127:0] d_a, q_a;
    logic [0:0]   req_b, ack_b, qv_b, rdy_b, ovf_b, clr_b;
    logic [31:0]  d_b, q_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          dut;
        int          ch;
        logic [31:0] data;
        int          exp_cyc;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cxapbasyncbridge_cdc_capt_bank #(.WIDTH(32), .NCHAN(4), .SYNC_STAGES(2), .CLAMP(1)) u_dut (
        .clk(clk), .reset(reset), .req_async(req_a), .d_async(d_a), .ack(ack_a),
        .q(q_a), .q_valid(qv_a), .q_ready(rdy_a), .ovf(ovf_a), .ovf_clr(clr_a));

    cxapbasyncbridge_cdc_capt_bank #(.WIDTH(32), .NCHAN(1), .SYNC_STAGES(3), .CLAMP(1)) u_dut3 (
        .clk(clk), .reset(reset), .req_async(req_b), .d_async(d_b), .ack(ack_b),
        .q(q_b), .q_valid(qv_b), .q_ready(rdy_b), .ovf(ovf_b), .ovf_clr(clr_b));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int dut, input int ch, input logic [31:0] data, input int exp_cyc);
        exp_t e;
        e.dut = dut; e.ch = ch; e.data = data; e.exp_cyc = exp_cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_valid_a(input int ch, input int max_cyc);
        bit seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (qv_a[ch]) seen = 1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_valid ch%0d: q_valid never rose within %0d cycles", ch, max_cyc);
        end
    endtask

    // Monitor: slots 0..3 are u_dut channels, slot 4 is u_dut3 channel 0.
    logic [4:0]  prev_v = '0;
    logic        mon_v;
    logic [31:0] mon_d;
    int          mon_dut, mon_ch, mon_idx;

    always @(negedge clk) begin
        for (int s = 0; s < 5; s++) begin
            if (s < 4) begin
                mon_v = qv_a[s]; mon_d = q_a[s*32 +: 32]; mon_dut = 0; mon_ch = s;
            end else begin
                mon_v = qv_b[0]; mon_d = q_b; mon_dut = 1; mon_ch = 0;
            end
            if (mon_v && !prev_v[s]) begin
                mon_idx = -1;
                for (int k = 0; k < sbq.size(); k++) begin
                    if (mon_idx < 0 && sbq[k].dut == mon_dut && sbq[k].ch == mon_ch) mon_idx = k;
                end
                if (mon_idx < 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_capture dut%0d ch%0d: got %0h expected no capture", mon_dut, mon_ch, mon_d);
                end else begin
                    chk($sformatf("capt_data dut%0d ch%0d", mon_dut, mon_ch), 128'(mon_d), 128'(sbq[mon_idx].data));
                    chk($sformatf("capt_latency dut%0d ch%0d", mon_dut, mon_ch), 128'(cyc), 128'(sbq[mon_idx].exp_cyc));
                    sbq.delete(mon_idx);
                end
            end
            prev_v[s] = mon_v;
        end
    end

    logic [3:0] order [4] = '{0, 2, 3, 1};
    logic [31:0] stag_data [4] = '{32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1357_9BDF, 32'hFFFF_0001};
    int rel_cyc;

    initial begin
        reset = 1'b1;
        req_a = '0; d_a = '0; rdy_a = '0; clr_a = '0;
        req_b = '0; d_b = '0; rdy_b = '1; clr_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_q",     q_a,   128'h0);
        chk("reset_valid", qv_a,  128'h0);
        chk("reset_ack",   ack_a, 128'h0);
        chk("reset_ovf",   ovf_a, 128'h0);

        // Payload churn with no request outstanding must never reach q.
        for (int i = 0; i < 8; i++) begin
            d_a = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("idle_clamp_q",     q_a,  128'h0);
            chk("idle_clamp_valid", qv_a, 128'h0);
        end

        // Single capture on ch0, held under back-pressure, then consumed.
        d_a[31:0] = 32'hA5A5_1234;
        req_a[0]  = 1'b1;
        push(0, 0, 32'hA5A5_1234, cyc + 3);
        wait_valid_a(0, 10);
        chk("capt_others_q", q_a[127:32], 128'h0);
        chk("capt_ack",      ack_a,       128'h0);
        chk("capt_ovf",      ovf_a,       128'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_q",     q_a[31:0], 128'hA5A5_1234);
            chk("hold_valid", qv_a[0],   128'h1);
        end
        rdy_a[0] = 1'b1;
        @(negedge clk);
        rdy_a[0] = 1'b0;
        chk("accept_valid", qv_a[0],   128'h0);
        chk("accept_ack",   ack_a[0],  128'h1);
        chk("accept_clamp", q_a[31:0], 128'h0);

        // Overflow on ch1: second toggle before consume.
        d_a[63:32] = 32'h1111_1111;
        req_a[1]   = 1'b1;
        push(0, 1, 32'h1111_1111, cyc + 3);
        wait_valid_a(1, 10);
        d_a[63:32] = 32'h2222_2222;
        req_a[1]   = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf_set",       ovf_a[1],   128'h1);
        chk("ovf_keep_q",    q_a[63:32], 128'h1111_1111);
        chk("ovf_keep_valid", qv_a[1],   128'h1);
        clr_a[1] = 1'b1;
        @(negedge clk);
        chk("ovf_clear", ovf_a[1], 128'h0);
        req_a[1] = 1'b1;
        repeat (3) @(negedge clk);
        clr_a[1] = 1'b0;
        chk("ovf_set_beats_clr", ovf_a[1],   128'h1);
        chk("ovf_keep_q2",       q_a[63:32], 128'h1111_1111);
        rdy_a[1] = 1'b1;
        @(negedge clk);
        chk("ovf_consume_valid", qv_a[1],  128'h0);
        chk("ovf_consume_ack",   ack_a[1], 128'h1);
        clr_a[1] = 1'b1;
        @(negedge clk);
        clr_a[1] = 1'b0;
        chk("ovf_final_clear", ovf_a[1], 128'h0);

        // Concurrent staggered requests across all four channels.
        rdy_a = 4'hF;
        for (int i = 0; i < 4; i++) begin
            d_a[order[i]*32 +: 32] = stag_data[i];
            req_a[order[i]]        = ~req_a[order[i]];
            push(0, int'(order[i]), stag_data[i], cyc + 3);
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("stagger_ack", ack_a, 128'(req_a));

        // Reset while ch0 holds a word; level-high requests recapture afterwards.
        rdy_a[0]  = 1'b0;
        d_a[31:0] = 32'hCAFE_F00D;
        req_a[0]  = 1'b1;
        push(0, 0, 32'hCAFE_F00D, cyc + 3);
        wait_valid_a(0, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_q",     q_a,   128'h0);
        chk("midreset_valid", qv_a,  128'h0);
        chk("midreset_ack",   ack_a, 128'h0);
        reset   = 1'b0;
        rel_cyc = cyc;
        for (int c = 0; c < 4; c++) begin
            if (req_a[c]) push(0, c, d_a[c*32 +: 32], rel_cyc + 3);
        end
        repeat (6) @(negedge clk);
        chk("recapt_q0", q_a[31:0], 128'hCAFE_F00D);
        rdy_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("recapt_ack", ack_a, 128'(req_a));

        // Three-stage synchroniser instance: latency 4.
        d_b   = 32'h5A5A_0F0F;
        req_b = 1'b1;
        push(1, 0, 32'h5A5A_0F0F, cyc + 4);
        repeat (8) @(negedge clk);
        chk("sync3_ack", ack_b, 128'h1);
        chk("sync3_ovf", ovf_b, 128'h0);

        repeat (2) @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending captures expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
